// File: rtl/bcd_timer_pkg.sv
// ============================================================================
// Module  : bcd_timer_pkg
// Brief   : Shared constants and the per-digit maximum helper for bcd_timer_n
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_timer_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 16;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    // Extracts the maximum value of digit idx from the packed DIGIT_MAX word
    function automatic logic [BCD_W-1:0] digit_max(
        input logic [BCD_W*MAX_DIGITS-1:0] packed_max,
        input int                          idx
    );
        return packed_max[idx*BCD_W +: BCD_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module  : bcd_digit
// Brief   : One BCD nibble with per-digit modulus, load clamp and carry/borrow out
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    input  logic             step_in,
    input  logic             dir,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] q,
    output logic [BCD_W-1:0] q_nxt,
    output logic             carry_out
);

    logic [BCD_W-1:0] r_q;
    logic [BCD_W-1:0] w_stepped;
    logic [BCD_W-1:0] w_clamped;
    logic             w_at_edge;

    // w_at_edge marks the value from which this digit rolls over in the current direction
    always_comb begin
        w_at_edge = (dir == DIR_UP) ? (r_q == max) : (r_q == '0);
        w_stepped = r_q;
        if (dir == DIR_UP) begin
            w_stepped = w_at_edge ? '0 : r_q + BCD_W'(1);
        end else begin
            w_stepped = w_at_edge ? max : r_q - BCD_W'(1);
        end
    end

    assign w_clamped = (load_val > max) ? max : load_val;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_clamped;
        end else if (step_in) begin
            r_q <= w_stepped;
        end
    end

    assign q         = r_q;
    assign q_nxt     = step_in ? w_stepped : r_q;
    assign carry_out = step_in && w_at_edge;

endmodule

`default_nettype wire

// File: rtl/bcd_timer_n.sv
// ============================================================================
// Module  : bcd_timer_n
// Brief   : Prescaled N-digit BCD up/down timer with wrap/stop and display scan
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_timer_n
    import bcd_timer_pkg::*;
#(
    parameter int                  PRESCALE  = 100_000_000,
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] DIGIT_MAX = 16'h5959,
    parameter int                  SCAN_DIV  = 50_000
)(
    input  logic                                        clk,
    input  logic                                        clr,
    input  logic                                        en,
    input  logic                                        dir,
    input  logic                                        mode,
    input  logic                                        load,
    input  logic [4*DIGITS-1:0]                         load_val,
    output logic [4*DIGITS-1:0]                         value,
    output logic                                        tick,
    output logic                                        tc,
    output logic                                        done,
    output logic [(DIGITS > 1 ? $clog2(DIGITS) : 1)-1:0] scan_sel,
    output logic                                        scan_tick
);

    localparam int PW       = $clog2(PRESCALE + 1);
    localparam int SW       = $clog2(SCAN_DIV + 1);
    localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_wide_w = BCD_W * MAX_DIGITS;

    localparam logic [PW-1:0]       c_pre_last  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]       c_scan_last = SW'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]    c_last_sel  = SEL_W'(DIGITS - 1);
    localparam logic [c_wide_w-1:0] c_max_wide  = c_wide_w'(DIGIT_MAX);

    logic [PW-1:0]           r_pcnt;
    logic [SW-1:0]           r_scnt;
    logic [SEL_W-1:0]        r_scan_sel;
    logic                    r_tc;
    logic                    r_done;

    logic [BCD_W*DIGITS-1:0] w_value;
    logic [BCD_W*DIGITS-1:0] w_value_nxt;
    logic [BCD_W*DIGITS-1:0] w_max_vec;
    logic [DIGITS:0]         w_carry;
    logic                    w_tick;
    logic                    w_scan_tick;
    logic                    w_try;
    logic                    w_step;
    logic                    w_hold_term;
    logic                    w_term_now;
    logic                    w_term_nxt;
    logic                    w_land_stop;

    assign w_tick      = en && (r_pcnt == c_pre_last);
    assign w_scan_tick = (r_scnt == c_scan_last);

    // In stop mode a step starting from terminal is converted into a done/tc event
    assign w_try       = w_tick && !load && !r_done;
    assign w_hold_term = w_try && (mode == MODE_STOP) && w_term_now;
    assign w_step      = w_try && !w_hold_term;
    assign w_land_stop = w_step && (mode == MODE_STOP) && w_term_nxt;

    assign w_term_now = (dir == DIR_UP) ? (w_value == w_max_vec) : (w_value == '0);
    assign w_term_nxt = (dir == DIR_UP) ? (w_value_nxt == w_max_vec) : (w_value_nxt == '0);

    assign w_carry[0] = w_step;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        localparam logic [BCD_W-1:0] c_max = digit_max(c_max_wide, i);

        assign w_max_vec[i*BCD_W +: BCD_W] = c_max;

        bcd_digit u_digit (
            .clk       (clk),
            .clr       (clr),
            .load      (load),
            .load_val  (load_val[i*BCD_W +: BCD_W]),
            .step_in   (w_carry[i]),
            .dir       (dir),
            .max       (c_max),
            .q         (w_value[i*BCD_W +: BCD_W]),
            .q_nxt     (w_value_nxt[i*BCD_W +: BCD_W]),
            .carry_out (w_carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (clr || load) begin
            r_pcnt <= '0;
        end else if (en) begin
            r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
        end
    end

    // Carry out of the top digit means the whole counter rolled over from terminal
    always_ff @(posedge clk) begin
        if (clr || load) begin
            r_tc   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tc <= ((mode == MODE_WRAP) && w_carry[DIGITS]) || w_land_stop || w_hold_term;
            if (w_land_stop || w_hold_term) begin
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_scnt     <= '0;
            r_scan_sel <= '0;
        end else if (w_scan_tick) begin
            r_scnt     <= '0;
            r_scan_sel <= (r_scan_sel == c_last_sel) ? '0 : r_scan_sel + SEL_W'(1);
        end else begin
            r_scnt <= r_scnt + SW'(1);
        end
    end

    assign value     = w_value;
    assign tick      = w_tick;
    assign tc        = r_tc;
    assign done      = r_done;
    assign scan_sel  = r_scan_sel;
    assign scan_tick = w_scan_tick;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timer_n.sv
// ============================================================================
// Module  : tb_bcd_timer_n
// Brief   : Self-checking bench for bcd_timer_n (PRESCALE=4, 4 digits, mm:ss, SCAN_DIV=3)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_timer_n;

    localparam int          PRESCALE  = 4;
    localparam int          DIGITS    = 4;
    localparam logic [15:0] DIGIT_MAX = 16'h5959;
    localparam int          SCAN_DIV  = 3;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        dir;
    logic        mode;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] value;
    logic        tick;
    logic        tc;
    logic        done;
    logic [1:0]  scan_sel;
    logic        scan_tick;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_v;

    bcd_timer_n #(
        .PRESCALE  (PRESCALE),
        .DIGITS    (DIGITS),
        .DIGIT_MAX (DIGIT_MAX),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .value     (value),
        .tick      (tick),
        .tc        (tc),
        .done      (done),
        .scan_sel  (scan_sel),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        cyc(1);
        load     = 1'b0;
    endtask

    // Bounded wait for the prescaler tick; an expired bound counts as a failure
    task automatic wait_tick(output int waited);
        waited = 0;
        while (tick !== 1'b1 && waited < 16) begin
            cyc(1);
            waited++;
        end
        n_checks++;
        if (tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, waited);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; dir = 1'b1; mode = 1'b0; load = 1'b0; load_val = '0;
        cyc(2);
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h required 0000", value); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b required 0", tc); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++; if (scan_sel !== 2'd0) begin n_fail++; $display("FAIL reset_scan_sel: got %0d required 0", scan_sel); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b required 0", tick); end
        clr = 1'b0;
    endtask

    task automatic test_count_up();
        int w;
        sb_q.push_back(16'h0001);
        sb_q.push_back(16'h0002);
        wait_tick(w);
        n_checks++; if (w !== 3) begin n_fail++; $display("FAIL first_tick_latency: got %0d cycles required 3", w); end
        cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL up_tick1: got %h required %h", value, exp_v); end
        wait_tick(w);
        n_checks++; if (w !== 3) begin n_fail++; $display("FAIL tick_period: got %0d cycles required 3", w); end
        cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL up_tick2: got %h required %h", value, exp_v); end
    endtask

    task automatic test_load_carry();
        int w;
        dir = 1'b1; mode = 1'b0;
        sb_q.push_back(16'h0959);
        do_load(16'h0959);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL load_0959: got %h required %h", value, exp_v); end
        sb_q.push_back(16'h1000);
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL carry_ripple: got %h required %h", value, exp_v); end
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL carry_tc: got %b required 0", tc); end
        sb_q.push_back(16'h0000);
        do_load(16'h5959);
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL wrap_up_value: got %h required %h", value, exp_v); end
        n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_up_tc: got %b required 1", tc); end
        cyc(1);
        n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL wrap_up_tc_width: got %b required 0", tc); end
    endtask

    task automatic test_wrap_down();
        int w;
        dir = 1'b0; mode = 1'b0;
        sb_q.push_back(16'h5959);
        do_load(16'h0000);
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL wrap_down_value: got %h required %h", value, exp_v); end
        n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL wrap_down_tc: got %b required 1", tc); end
    endtask

    task automatic test_stop_down();
        int w;
        int n_ticks = 0;
        int n_tc    = 0;
        int n_bad   = 0;
        dir = 1'b0; mode = 1'b1;
        sb_q.push_back(16'h0001);
        sb_q.push_back(16'h0000);
        do_load(16'h0002);
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL stop_step1: got %h required %h", value, exp_v); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stop_early_done: got %b required 0", done); end
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL stop_land: got %h required %h", value, exp_v); end
        n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL stop_land_tc: got %b required 1", tc); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stop_land_done: got %b required 1", done); end
        for (int k = 0; k < 44; k++) begin
            cyc(1);
            if (tick === 1'b1) n_ticks++;
            if (tc === 1'b1) n_tc++;
            if (value !== 16'h0000) n_bad++;
        end
        n_checks++; if (n_ticks < 10) begin n_fail++; $display("FAIL stop_ticks_run: got %0d ticks required >=10", n_ticks); end
        n_checks++; if (n_tc !== 0) begin n_fail++; $display("FAIL stop_tc_quiet: got %0d tc pulses required 0", n_tc); end
        n_checks++; if (n_bad !== 0) begin n_fail++; $display("FAIL stop_value_held: got %0d moved cycles required 0", n_bad); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stop_done_sticky: got %b required 1", done); end
        do_load(16'h0000);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_clears_done: got %b required 0", done); end
        sb_q.push_back(16'h0000);
        wait_tick(w); cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL term_load_value: got %h required %h", value, exp_v); end
        n_checks++; if (done !== 1'b1 || tc !== 1'b1) begin n_fail++; $display("FAIL term_load_flags: got done=%b tc=%b required done=1 tc=1", done, tc); end
        do_load(16'h0300);
        n_checks++; if (done !== 1'b0 || value !== 16'h0300) begin n_fail++; $display("FAIL reload: got done=%b value=%h required done=0 value=0300", done, value); end
    endtask

    task automatic test_clamp();
        sb_q.push_back(16'h5959);
        sb_q.push_back(16'h0909);
        do_load(16'h7A9F);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL clamp_7A9F: got %h required %h", value, exp_v); end
        do_load(16'h0A0B);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL clamp_0A0B: got %h required %h", value, exp_v); end
    endtask

    task automatic test_load_on_tick();
        int w;
        dir = 1'b1; mode = 1'b0;
        do_load(16'h0100);
        sb_q.push_back(16'h0200);
        sb_q.push_back(16'h0201);
        wait_tick(w);
        load = 1'b1; load_val = 16'h0200;
        cyc(1);
        load = 1'b0;
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL load_beats_tick: got %h required %h", value, exp_v); end
        wait_tick(w);
        n_checks++; if (w !== 3) begin n_fail++; $display("FAIL load_restarts_prescaler: got %0d cycles required 3", w); end
        cyc(1);
        exp_v = sb_q.pop_front();
        n_checks++; if (value !== exp_v) begin n_fail++; $display("FAIL after_load_tick: got %h required %h", value, exp_v); end
    endtask

    task automatic test_clr_mid();
        dir = 1'b1; mode = 1'b0;
        do_load(16'h0123);
        cyc(2);
        n_checks++; if (tick !== 1'b0 || value !== 16'h0123) begin n_fail++; $display("FAIL clr_setup: got tick=%b value=%h required tick=0 value=0123", tick, value); end
        clr = 1'b1; en = 1'b0;
        cyc(1);
        n_checks++; if (value !== 16'h0000 || tc !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_mid_regs: got value=%h tc=%b done=%b required 0", value, tc, done); end
        n_checks++; if (scan_sel !== 2'd0 || scan_tick !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("FAIL clr_mid_scan: got sel=%0d stick=%b tick=%b required 0", scan_sel, scan_tick, tick); end
        clr = 1'b0;
    endtask

    task automatic test_scan();
        int w;
        sb_q.push_back(16'd1);
        sb_q.push_back(16'd2);
        sb_q.push_back(16'd3);
        sb_q.push_back(16'd0);
        sb_q.push_back(16'd1);
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (scan_tick !== 1'b1 && w < 8) begin
                cyc(1);
                w++;
            end
            n_checks++; if (w !== 2) begin n_fail++; $display("FAIL scan_period_%0d: got %0d cycles required 2", k, w); end
            cyc(1);
            exp_v = sb_q.pop_front();
            n_checks++; if ({14'd0, scan_sel} !== exp_v) begin n_fail++; $display("FAIL scan_sel_%0d: got %0d required %0d", k, scan_sel, exp_v); end
        end
        n_checks++; if (value !== 16'h0000 || tick !== 1'b0) begin n_fail++; $display("FAIL scan_en_off: got value=%h tick=%b required 0000/0", value, tick); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_carry();
        test_wrap_down();
        test_stop_down();
        test_clamp();
        test_load_on_tick();
        test_clr_mid();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
